// File: rtl/wb2arbiter_pkg.sv
// Shared types and default constants for the Wishbone-to-arbiter request bridge.
package wb2arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_RSP   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam logic [31:0] DEF_BASE_ADDR    = 32'h3800_0000;
  localparam logic [31:0] DEF_BASE_MASK    = 32'hFF80_0000;
  localparam logic [31:0] DEF_TIMEOUT_DATA = 32'hDEAD_BEEF;

  // A disabled timeout (0 cycles) still needs a 1-bit counter to stay legal.
  function automatic int timer_width(input int cyc);
    return (cyc == 0) ? 1 : $clog2(cyc + 1);
  endfunction

endpackage

// File: rtl/wb2arbiter_timer.sv
// Saturating cycle counter with synchronous clear, enable and a single-cycle expire flag at LIMIT-1.
module wb2arbiter_timer #(
  parameter int LIMIT = 1024,
  parameter int CNT_W = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] cnt,
  output logic             expire
);

  localparam logic [CNT_W-1:0] LIM_MAX = CNT_W'(LIMIT);
  localparam logic [CNT_W-1:0] LIM_M1  = CNT_W'((LIMIT == 0) ? 0 : LIMIT - 1);
  localparam logic             LIM_ON  = (LIMIT != 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && LIM_ON && (cnt != LIM_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expire = en && LIM_ON && (cnt == LIM_M1);

endmodule

// File: rtl/wb2arbiter_reg.sv
// Registered Wishbone slave that forwards one access at a time to an arbiter request port,
// with byte enables, a request timeout and draining of abandoned cycles.
module wb2arbiter_reg
  import wb2arbiter_pkg::*;
#(
  parameter int                ADDR_W       = 23,
  parameter int                DATA_W       = 32,
  parameter logic [31:0]       BASE_ADDR    = DEF_BASE_ADDR,
  parameter logic [31:0]       BASE_MASK    = DEF_BASE_MASK,
  parameter int                TIMEOUT_CYC  = 1024,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA = DEF_TIMEOUT_DATA
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_n_i,
  input  logic                wbs_stb_i,
  input  logic                wbs_cyc_i,
  input  logic                wbs_we_i,
  input  logic [DATA_W/8-1:0] wbs_sel_i,
  input  logic [DATA_W-1:0]   wbs_dat_i,
  input  logic [31:0]         wbs_adr_i,
  output logic                wbs_ack_o,
  output logic [DATA_W-1:0]   wbs_dat_o,
  output logic                cpu_req_valid,
  output logic [ADDR_W-1:0]   cpu_req_addr,
  output logic                cpu_req_rw,
  output logic [DATA_W-1:0]   cpu_req_wdata,
  output logic [DATA_W/8-1:0] cpu_req_be,
  input  logic                cpu_req_ack,
  input  logic [DATA_W-1:0]   cpu_rsp_rdata,
  output logic                busy_o,
  output logic                timeout_o,
  input  logic                timeout_clr_i
);

  localparam int TMR_W = timer_width(TIMEOUT_CYC);

  function automatic logic window_hit(input logic [31:0] adr);
    return (adr & BASE_MASK) == BASE_ADDR;
  endfunction

  state_e            state, state_n;
  logic              ld_req;
  logic              ld_rsp;
  logic [DATA_W-1:0] rsp_data;
  logic              set_to;
  logic              tmr_clr;
  logic              tmr_en;
  logic              tmr_expire;
  logic [TMR_W-1:0]  tmr_cnt;

  wb2arbiter_timer #(
    .LIMIT (TIMEOUT_CYC),
    .CNT_W (TMR_W)
  ) u_timer (
    .clk    (wb_clk_i),
    .rst_n  (wb_rst_n_i),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .cnt    (tmr_cnt),
    .expire (tmr_expire)
  );

  assign tmr_en = (state == ST_REQ) || (state == ST_DRAIN);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Precedence in REQ: arbiter ack, then master abandoning the cycle, then timeout.
  always_comb begin
    state_n  = state;
    ld_req   = 1'b0;
    ld_rsp   = 1'b0;
    rsp_data = '0;
    set_to   = 1'b0;
    tmr_clr  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wbs_stb_i && wbs_cyc_i && window_hit(wbs_adr_i)) begin
          ld_req  = 1'b1;
          tmr_clr = 1'b1;
          state_n = ST_REQ;
        end
      end
      ST_REQ: begin
        if (cpu_req_ack) begin
          ld_rsp   = 1'b1;
          rsp_data = cpu_req_rw ? '0 : cpu_rsp_rdata;
          state_n  = ST_RSP;
        end else if (!wbs_cyc_i) begin
          state_n = ST_DRAIN;
        end else if (tmr_expire) begin
          ld_rsp   = 1'b1;
          rsp_data = TIMEOUT_DATA;
          set_to   = 1'b1;
          state_n  = ST_RSP;
        end
      end
      ST_RSP: begin
        state_n = ST_IDLE;
      end
      ST_DRAIN: begin
        if (cpu_req_ack) begin
          state_n = ST_IDLE;
        end else if (tmr_expire) begin
          set_to  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      cpu_req_addr  <= '0;
      cpu_req_rw    <= 1'b0;
      cpu_req_wdata <= '0;
      cpu_req_be    <= '0;
    end else if (ld_req) begin
      cpu_req_addr  <= wbs_adr_i[ADDR_W-1:0];
      cpu_req_rw    <= wbs_we_i;
      cpu_req_wdata <= wbs_dat_i;
      cpu_req_be    <= wbs_sel_i;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      wbs_dat_o <= '0;
    end else if (ld_rsp) begin
      wbs_dat_o <= rsp_data;
    end
  end

  // Set has priority so a timeout coinciding with a clear is never lost.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      timeout_o <= 1'b0;
    end else if (set_to) begin
      timeout_o <= 1'b1;
    end else if (timeout_clr_i) begin
      timeout_o <= 1'b0;
    end
  end

  assign cpu_req_valid = (state == ST_REQ) || (state == ST_DRAIN);
  assign wbs_ack_o     = (state == ST_RSP);
  assign busy_o        = (state != ST_IDLE);

endmodule

// File: tb/tb_wb2arbiter_reg.sv
// Directed bench for wb2arbiter_reg: hits, misses, timeout, abandoned cycles and async reset.
module tb_wb2arbiter_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] dat_i, adr;
  logic        ack_o;
  logic [31:0] dat_o;
  logic        req_valid;
  logic [22:0] req_addr;
  logic        req_rw;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        req_ack;
  logic [31:0] rsp_rdata;
  logic        busy, tmo, tmo_clr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb2arbiter_reg #(
    .TIMEOUT_CYC (8)
  ) dut (
    .wb_clk_i      (clk),
    .wb_rst_n_i    (rst_n),
    .wbs_stb_i     (stb),
    .wbs_cyc_i     (cyc),
    .wbs_we_i      (we),
    .wbs_sel_i     (sel),
    .wbs_dat_i     (dat_i),
    .wbs_adr_i     (adr),
    .wbs_ack_o     (ack_o),
    .wbs_dat_o     (dat_o),
    .cpu_req_valid (req_valid),
    .cpu_req_addr  (req_addr),
    .cpu_req_rw    (req_rw),
    .cpu_req_wdata (req_wdata),
    .cpu_req_be    (req_be),
    .cpu_req_ack   (req_ack),
    .cpu_rsp_rdata (rsp_rdata),
    .busy_o        (busy),
    .timeout_o     (tmo),
    .timeout_clr_i (tmo_clr)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wb_start(input logic w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    stb = 1'b1; cyc = 1'b1; we = w; adr = a; sel = s; dat_i = d;
  endtask

  task automatic wb_stop();
    stb = 1'b0; cyc = 1'b0; we = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = '0; dat_i = '0; adr = '0;
    req_ack = 1'b0; rsp_rdata = '0; tmo_clr = 1'b0;
    repeat (3) tick();
    chk("rst_valid", {31'd0, req_valid}, 32'd0);
    chk("rst_ack",   {31'd0, ack_o},     32'd0);
    chk("rst_busy",  {31'd0, busy},      32'd0);
    chk("rst_dat",   dat_o,              32'd0);
    chk("rst_addr",  {9'd0, req_addr},   32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: read hit, ack two cycles after valid
    wb_start(1'b0, 32'h3800_0004, 4'hF, 32'h0);
    tick();
    chk("t1_valid_c1", {31'd0, req_valid}, 32'd1);
    chk("t1_addr",     {9'd0, req_addr},   32'h4);
    chk("t1_rw",       {31'd0, req_rw},    32'd0);
    chk("t1_busy",     {31'd0, busy},      32'd1);
    tick();
    chk("t1_ack_c2",   {31'd0, ack_o},     32'd0);
    tick();
    req_ack = 1'b1; rsp_rdata = 32'h1234_5678;
    chk("t1_ack_c3",   {31'd0, ack_o},     32'd0);
    tick();
    req_ack = 1'b0; rsp_rdata = 32'h0;
    wb_stop();
    chk("t1_ack_c4",   {31'd0, ack_o},     32'd1);
    chk("t1_dat",      dat_o,              32'h1234_5678);
    chk("t1_valid_rsp",{31'd0, req_valid}, 32'd0);
    tick();
    chk("t1_ack_c5",   {31'd0, ack_o},     32'd0);
    chk("t1_idle",     {31'd0, busy},      32'd0);
    chk("t1_dat_hold", dat_o,              32'h1234_5678);

    // 2: write with partial byte enables; write data must stay latched
    wb_start(1'b1, 32'h3800_0010, 4'b0011, 32'hAABB_CCDD);
    tick();
    chk("t2_addr",  {9'd0, req_addr},   32'h10);
    chk("t2_be",    {28'd0, req_be},    32'h3);
    chk("t2_rw",    {31'd0, req_rw},    32'd1);
    chk("t2_wdata", req_wdata,          32'hAABB_CCDD);
    dat_i = 32'h0101_0101;
    tick();
    chk("t2_wdata_stable", req_wdata,   32'hAABB_CCDD);
    req_ack = 1'b1; rsp_rdata = 32'hFFFF_FFFF;
    tick();
    req_ack = 1'b0;
    wb_stop();
    chk("t2_ack",   {31'd0, ack_o},     32'd1);
    chk("t2_dat",   dat_o,              32'h0);
    tick();
    chk("t2_ack_once", {31'd0, ack_o},  32'd0);

    // 3: address outside the window
    wb_start(1'b0, 32'h3000_0000, 4'hF, 32'h0);
    tick();
    chk("t3_valid", {31'd0, req_valid}, 32'd0);
    chk("t3_busy",  {31'd0, busy},      32'd0);
    tick();
    chk("t3_ack",   {31'd0, ack_o},     32'd0);
    wb_stop();
    tick();

    // 4: silent arbiter -> timeout after 8 REQ cycles
    wb_start(1'b0, 32'h3800_0020, 4'hF, 32'h0);
    tick();
    repeat (7) tick();
    chk("t4_still_req", {31'd0, req_valid}, 32'd1);
    chk("t4_no_to_yet", {31'd0, tmo},       32'd0);
    tick();
    wb_stop();
    chk("t4_ack", {31'd0, ack_o}, 32'd1);
    chk("t4_dat", dat_o,          32'hDEAD_BEEF);
    chk("t4_to",  {31'd0, tmo},   32'd1);
    tick();
    req_ack = 1'b1; rsp_rdata = 32'h7777_7777;
    tick();
    req_ack = 1'b0;
    chk("t4_late_ack_busy", {31'd0, busy},  32'd0);
    chk("t4_late_ack_ack",  {31'd0, ack_o}, 32'd0);
    chk("t4_late_ack_dat",  dat_o,          32'hDEAD_BEEF);
    chk("t4_to_sticky",     {31'd0, tmo},   32'd1);
    tmo_clr = 1'b1;
    tick();
    tmo_clr = 1'b0;
    chk("t4_to_clr", {31'd0, tmo}, 32'd0);

    // 5: master drops cyc one cycle into REQ -> drain until arbiter acks
    wb_start(1'b0, 32'h3800_0030, 4'hF, 32'h0);
    tick();
    wb_stop();
    tick();
    chk("t5_drain_valid", {31'd0, req_valid}, 32'd1);
    chk("t5_drain_busy",  {31'd0, busy},      32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_drain_noack", {31'd0, ack_o},   32'd0);
    end
    req_ack = 1'b1; rsp_rdata = 32'h4444_4444;
    tick();
    req_ack = 1'b0;
    chk("t5_idle",   {31'd0, busy},      32'd0);
    chk("t5_valid",  {31'd0, req_valid}, 32'd0);
    chk("t5_noack",  {31'd0, ack_o},     32'd0);
    chk("t5_dat",    dat_o,              32'hDEAD_BEEF);
    chk("t5_no_to",  {31'd0, tmo},       32'd0);

    // 6: async reset in the middle of REQ, then a fresh read
    wb_start(1'b0, 32'h3800_0040, 4'hF, 32'h0);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("t6_valid", {31'd0, req_valid}, 32'd0);
    chk("t6_busy",  {31'd0, busy},      32'd0);
    chk("t6_addr",  {9'd0, req_addr},   32'd0);
    chk("t6_dat",   dat_o,              32'd0);
    wb_stop();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    wb_start(1'b0, 32'h3800_0044, 4'hF, 32'h0);
    tick();
    chk("t6_fresh_addr", {9'd0, req_addr}, 32'h44);
    req_ack = 1'b1; rsp_rdata = 32'h5555_AAAA;
    tick();
    req_ack = 1'b0;
    wb_stop();
    chk("t6_fresh_ack", {31'd0, ack_o}, 32'd1);
    chk("t6_fresh_dat", dat_o,          32'h5555_AAAA);
    tick();
    chk("t6_fresh_idle", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
